// File: rtl/formula_multi_pkg.sv
// Shared types and sizing helpers for the multi-unit isqrt sum FSM.
package formula_multi_pkg;

  typedef enum logic [1:0] {st_idle, st_wait, st_done} state_t;

  function automatic int rounds(input int n_args, input int n_isqrt);
    return (n_args + n_isqrt - 1) / n_isqrt;
  endfunction

  // Sum of n_args roots of w-bit values never exceeds this width.
  function automatic int acc_width(input int w, input int n_args);
    return w / 2 + $clog2(n_args + 1);
  endfunction

endpackage

// File: rtl/isqrt_round_collector.sv
// Tracks which isqrt units of the current round are still outstanding and
// sums the roots that return in the present cycle.
module isqrt_round_collector
  import formula_multi_pkg::*;
#(
  parameter int N_ISQRT = 2,
  parameter int W       = 32,
  localparam int SW     = W / 2 + $clog2(N_ISQRT + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [N_ISQRT-1:0]     load_mask,
  input  logic [N_ISQRT-1:0]     y_vld,
  input  logic [N_ISQRT*W/2-1:0] y,
  output logic [SW-1:0]          sum,
  output logic                   round_done
);

  localparam int H = W / 2;

  logic [N_ISQRT-1:0] outstanding;
  logic [N_ISQRT-1:0] hit;
  logic [N_ISQRT-1:0] remaining;

  // Strobes from units that are not outstanding never reach the sum.
  always_comb begin
    hit        = y_vld & outstanding;
    remaining  = outstanding & ~hit;
    round_done = (|outstanding) && !(|remaining);
    sum        = '0;
    for (int k = 0; k < N_ISQRT; k++) begin
      if (hit[k]) sum = sum + SW'(y[k*H +: H]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       outstanding <= '0;
    else if (load) outstanding <= load_mask;
    else           outstanding <= remaining;
  end

endmodule

// File: rtl/formula_1_multi_isqrt_fsm.sv
// Sums the integer square roots of N_ARGS arguments by issuing them in
// rounds of up to N_ISQRT to a bank of external isqrt units.
module formula_1_multi_isqrt_fsm
  import formula_multi_pkg::*;
#(
  parameter int N_ARGS  = 3,
  parameter int N_ISQRT = 2,
  parameter int W       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arg_vld,
  output logic                   arg_rdy,
  input  logic [N_ARGS*W-1:0]    args,
  output logic                   res_vld,
  output logic [W-1:0]           res,
  output logic [N_ISQRT-1:0]     isqrt_x_vld,
  output logic [N_ISQRT*W-1:0]   isqrt_x,
  input  logic [N_ISQRT-1:0]     isqrt_y_vld,
  input  logic [N_ISQRT*W/2-1:0] isqrt_y
);

  localparam int R  = rounds(N_ARGS, N_ISQRT);
  localparam int AW = acc_width(W, N_ARGS);
  localparam int RW = (R > 1) ? $clog2(R) : 1;
  localparam int SW = W / 2 + $clog2(N_ISQRT + 1);
  localparam int NP = R * N_ISQRT;

  if (N_ARGS < 1 || N_ISQRT < 1 || N_ISQRT > N_ARGS || (W % 2) != 0 || AW > W)
  begin : g_param_check
    $error("formula_1_multi_isqrt_fsm: illegal parameter combination");
  end

  state_t              state, state_nxt;
  logic [N_ARGS*W-1:0] args_q;
  logic [RW-1:0]       round;
  logic [RW-1:0]       issue_round;
  logic                issue;
  logic [NP*W-1:0]     issue_src;
  logic [AW-1:0]       acc;
  logic [SW-1:0]       sum;
  logic                round_done;

  always_comb begin
    state_nxt   = state;
    issue       = 1'b0;
    issue_round = round;
    issue_src   = (NP*W)'(args_q);
    unique case (state)
      st_idle: if (arg_vld) begin
        // Round 0 goes out in the acceptance cycle, straight from the inputs.
        issue       = 1'b1;
        issue_round = '0;
        issue_src   = (NP*W)'(args);
        state_nxt   = st_wait;
      end
      st_wait: if (round_done) begin
        if (round == RW'(R - 1)) begin
          state_nxt = st_done;
        end else begin
          issue       = 1'b1;
          issue_round = round + 1'b1;
        end
      end
      st_done: state_nxt = st_idle;
      default: state_nxt = st_idle;
    endcase
    if (rst) issue = 1'b0;
  end

  // Units beyond the last argument stay silent in a partial final round.
  always_comb begin
    isqrt_x_vld = '0;
    isqrt_x     = '0;
    for (int r = 0; r < R; r++) begin
      for (int k = 0; k < N_ISQRT; k++) begin
        if (issue && issue_round == RW'(r) && (r * N_ISQRT + k) < N_ARGS) begin
          isqrt_x_vld[k]     = 1'b1;
          isqrt_x[k*W +: W]  = issue_src[(r*N_ISQRT + k)*W +: W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= st_idle;
      round <= '0;
    end else begin
      state <= state_nxt;
      if (issue) round <= issue_round;
    end
  end

  always_ff @(posedge clk) begin
    if (state == st_idle && arg_vld) args_q <= args;
    if (state == st_idle)      acc <= '0;
    else if (state == st_wait) acc <= acc + AW'(sum);
  end

  isqrt_round_collector #(
    .N_ISQRT (N_ISQRT),
    .W       (W)
  ) u_collector (
    .clk        (clk),
    .rst        (rst),
    .load       (issue),
    .load_mask  (isqrt_x_vld),
    .y_vld      (isqrt_y_vld),
    .y          (isqrt_y),
    .sum        (sum),
    .round_done (round_done)
  );

  assign arg_rdy = (state == st_idle);
  assign res_vld = (state == st_done);
  assign res     = res_vld ? W'(acc) : '0;

endmodule

// File: tb/tb_formula_1_multi_isqrt_fsm.sv
// Directed bench: default 3-arg/2-unit instance plus a 5-arg/2-unit instance,
// both served by a behavioural fixed-latency isqrt model.
module tb_formula_1_multi_isqrt_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A: defaults
  logic         arg_vld_a = 1'b0, arg_rdy_a, res_vld_a;
  logic [95:0]  args_a = '0;
  logic [31:0]  res_a;
  logic [1:0]   xv_a, yv_a;
  logic [63:0]  x_a;
  logic [31:0]  y_a;
  // instance B: five arguments
  logic         arg_vld_b = 1'b0, arg_rdy_b, res_vld_b;
  logic [159:0] args_b = '0;
  logic [31:0]  res_b;
  logic [1:0]   xv_b, yv_b;
  logic [63:0]  x_b;
  logic [31:0]  y_b;

  formula_1_multi_isqrt_fsm u_dut (
    .clk(clk), .rst(rst), .arg_vld(arg_vld_a), .arg_rdy(arg_rdy_a), .args(args_a),
    .res_vld(res_vld_a), .res(res_a), .isqrt_x_vld(xv_a), .isqrt_x(x_a),
    .isqrt_y_vld(yv_a), .isqrt_y(y_a)
  );

  formula_1_multi_isqrt_fsm #(.N_ARGS(5), .N_ISQRT(2), .W(32)) u_dut5 (
    .clk(clk), .rst(rst), .arg_vld(arg_vld_b), .arg_rdy(arg_rdy_b), .args(args_b),
    .res_vld(res_vld_b), .res(res_b), .isqrt_x_vld(xv_b), .isqrt_x(x_b),
    .isqrt_y_vld(yv_b), .isqrt_y(y_b)
  );

  // Units 0,1 serve A; units 2,3 serve B.
  logic [3:0]   mx_vld;
  logic [127:0] mx;
  logic [3:0]   my_vld = '0;
  logic [63:0]  my = '0;
  logic [1:0]   spur_vld = '0;
  logic [31:0]  spur_y = '0;
  int           lat [4] = '{4, 4, 4, 4};
  int           cnt [4] = '{0, 0, 0, 0};
  logic [15:0]  val [4] = '{16'd0, 16'd0, 16'd0, 16'd0};

  assign mx_vld = {xv_b, xv_a};
  assign mx     = {x_b, x_a};
  assign yv_a   = my_vld[1:0] | spur_vld;
  assign y_a    = my[31:0] | spur_y;
  assign yv_b   = my_vld[3:2];
  assign y_b    = my[63:32];

  function automatic logic [15:0] isqrt(input logic [31:0] x);
    logic [15:0] r;
    logic [15:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (16'd1 << b);
      if ({16'd0, t} * {16'd0, t} <= x) r = t;
    end
    return r;
  endfunction

  always begin
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      my_vld[k] = 1'b0;
      if (cnt[k] > 0) begin
        cnt[k] = cnt[k] - 1;
        if (cnt[k] == 0) begin
          my_vld[k]       = 1'b1;
          my[k*16 +: 16]  = val[k];
        end
      end
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      if (mx_vld[k]) begin
        cnt[k] = lat[k];
        val[k] = isqrt(mx[k*32 +: 32]);
      end
    end
  end

  // Event log sampled mid-cycle.
  int          iss_cyc [4][64];
  logic [31:0] iss_x   [4][64];
  int          iss_n   [4] = '{0, 0, 0, 0};
  int          res_cnt_a = 0, res_cyc_a = 0, res_cnt_b = 0, res_cyc_b = 0;
  logic [31:0] res_val_a = '0, res_val_b = '0;
  int          idle_bad = 0;

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (mx_vld[k] && iss_n[k] < 64) begin
        iss_cyc[k][iss_n[k]] = cyc;
        iss_x[k][iss_n[k]]   = mx[k*32 +: 32];
        iss_n[k]             = iss_n[k] + 1;
      end
    end
    if (res_vld_a) begin
      res_val_a = res_a; res_cyc_a = cyc; res_cnt_a = res_cnt_a + 1;
    end else if (res_a != 32'd0) idle_bad = idle_bad + 1;
    if (res_vld_b) begin
      res_val_b = res_b; res_cyc_b = cyc; res_cnt_b = res_cnt_b + 1;
    end else if (res_b != 32'd0) idle_bad = idle_bad + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int t0       = 0;
  int base [4] = '{0, 0, 0, 0};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a(input logic [95:0] a);
    for (int k = 0; k < 4; k++) base[k] = iss_n[k];
    check("a_rdy_before_start", arg_rdy_a, 1);
    args_a = a; arg_vld_a = 1'b1; t0 = cyc;
    tick();
    arg_vld_a = 1'b0;
  endtask

  task automatic start_b(input logic [159:0] a);
    for (int k = 0; k < 4; k++) base[k] = iss_n[k];
    check("b_rdy_before_start", arg_rdy_b, 1);
    args_b = a; arg_vld_b = 1'b1; t0 = cyc;
    tick();
    arg_vld_b = 1'b0;
  endtask

  task automatic wait_res_a(input string tag);
    int s;
    s = res_cnt_a;
    for (int i = 0; i < 200; i++) begin
      if (res_cnt_a != s) break;
      tick();
    end
    check({tag, "_done"}, res_cnt_a - s, 1);
  endtask

  task automatic wait_res_b(input string tag);
    int s;
    s = res_cnt_b;
    for (int i = 0; i < 200; i++) begin
      if (res_cnt_b != s) break;
      tick();
    end
    check({tag, "_done"}, res_cnt_b - s, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_arg_rdy", arg_rdy_a, 1);
    check("rst_res_vld", res_vld_a, 0);
    check("rst_x_vld", xv_a, 0);
    check("rst_res", res_a, 0);
    check("rst_arg_rdy_b", arg_rdy_b, 1);
    tick();

    // basic sum 16,25,36 -> 4+5+6
    start_a({32'd36, 32'd25, 32'd16});
    wait_res_a("basic");
    check("basic_u0_r0_cyc", iss_cyc[0][base[0]], t0);
    check("basic_u0_r0_x", iss_x[0][base[0]], 16);
    check("basic_u1_r0_cyc", iss_cyc[1][base[1]], t0);
    check("basic_u1_r0_x", iss_x[1][base[1]], 25);
    check("basic_u0_r1_cyc", iss_cyc[0][base[0]+1], t0 + 4);
    check("basic_u0_r1_x", iss_x[0][base[0]+1], 36);
    check("basic_u0_count", iss_n[0] - base[0], 2);
    check("basic_u1_count", iss_n[1] - base[1], 1);
    check("basic_res_cyc", res_cyc_a, t0 + 9);
    check("basic_res", res_val_a, 15);
    check("basic_rdy_after", arg_rdy_a, 1);
    tick();

    // maximum values
    start_a({32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    wait_res_a("max");
    check("max_res", res_val_a, 196605);
    tick();

    // unit 1 returns three cycles after unit 0
    lat[1] = 7;
    start_a({32'd36, 32'd25, 32'd16});
    wait_res_a("skew");
    check("skew_u0_r1_cyc", iss_cyc[0][base[0]+1], t0 + 7);
    check("skew_res_cyc", res_cyc_a, t0 + 12);
    check("skew_res", res_val_a, 15);
    lat[1] = 4;
    tick();

    // arg_vld during WAIT and a spurious unit-1 strobe
    start_a({32'd36, 32'd25, 32'd16});
    tick();
    args_a = {32'd100, 32'd100, 32'd100}; arg_vld_a = 1'b1;
    tick();
    arg_vld_a = 1'b0;
    tick(); tick();
    spur_vld = 2'b10; spur_y = {16'd1000, 16'd0};
    tick();
    spur_vld = '0; spur_y = '0;
    wait_res_a("ignore");
    check("ignore_u0_r1_x", iss_x[0][base[0]+1], 36);
    check("ignore_u0_count", iss_n[0] - base[0], 2);
    check("ignore_res", res_val_a, 15);
    tick();

    // reset during WAIT, late results must be dropped
    start_a({32'd36, 32'd25, 32'd16});
    s = res_cnt_a;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_arg_rdy", arg_rdy_a, 1);
    check("mid_rst_res_vld", res_vld_a, 0);
    repeat (12) tick();
    check("mid_rst_no_res", res_cnt_a - s, 0);
    check("mid_rst_u0_count", iss_n[0] - base[0], 1);
    check("mid_rst_u1_count", iss_n[1] - base[1], 1);
    start_a({32'd1, 32'd0, 32'd0});
    wait_res_a("after_rst");
    check("after_rst_res", res_val_a, 1);
    tick();

    // five args over three rounds: 1,4,9,16,100 -> 1+2+3+4+10
    start_b({32'd100, 32'd16, 32'd9, 32'd4, 32'd1});
    wait_res_b("multi");
    check("multi_u0_count", iss_n[2] - base[2], 3);
    check("multi_u1_count", iss_n[3] - base[3], 2);
    check("multi_u0_r2_cyc", iss_cyc[2][base[2]+2], t0 + 8);
    check("multi_u0_r2_x", iss_x[2][base[2]+2], 100);
    check("multi_u1_r1_x", iss_x[3][base[3]+1], 16);
    check("multi_res_cyc", res_cyc_b, t0 + 13);
    check("multi_res", res_val_b, 20);
    tick();

    check("res_zero_when_idle", idle_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
